mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage_pkg.sv | 22 ++
 rtl/mem_wb_stage_if.sv | 39 +++
 rtl/mem_wb_stage_load_align.sv | 54 +++++
 rtl/mem_wb_stage.sv | 171 +++++++++++++++++
 tb/tb_mem_wb_stage.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared constants for the MEM/WB pipeline stage.
// Holds the load-type codes, the FSM state encoding and a few common
// constant names used by the stage and its load-alignment helper.
package mem_wb_stage_pkg;

  // Load-type codes as presented on loadType_i. Unlisted codes behave as LW.
  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LHU = 3'b010;
  localparam logic [2:0] LT_LB  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;

  // Stage FSM encoding (also visible on the debug state output).
  localparam logic [1:0] ST_EMPTY     = 2'd0;
  localparam logic [1:0] ST_WAIT_LOAD = 2'd1;
  localparam logic [1:0] ST_COMMIT    = 2'd2;

  localparam logic        ENABLE    = 1'b1;
  localparam logic        DISABLE   = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Bundle of the MEM -> WB handshake, load-return and register-file write
// signals. Signal names keep their _i/_o suffix as seen from the stage.
//   master : upstream MEM stage / memory / environment
//   slave  : the mem_wb_stage itself
// Handshake: an instruction transfers on a clock edge where valid_i and
// ready_o are both 1 and flush_i is 0; valid_i and its payload must be held
// until that edge; ready_o does not depend combinationally on valid_i.
interface mem_wb_stage_if;
  logic        valid_i;
  logic        ready_o;
  logic        RegWrite_i;
  logic        MemToReg_i;
  logic [4:0]  regDst_i;
  logic [31:0] aluResult_i;
  logic [2:0]  loadType_i;
  logic [31:0] memData_i;
  logic        memDataValid_i;
  logic        flush_i;
  logic [4:0]  writeRegDst_o;
  logic [31:0] writeRegData_o;
  logic        RegWrite_o;
  logic        alignErr_o;
  logic        timeoutErr_o;
  logic [31:0] retired_o;

  modport master (
    output valid_i, RegWrite_i, MemToReg_i, regDst_i, aluResult_i,
           loadType_i, memData_i, memDataValid_i, flush_i,
    input  ready_o, writeRegDst_o, writeRegData_o, RegWrite_o,
           alignErr_o, timeoutErr_o, retired_o
  );

  modport slave (
    input  valid_i, RegWrite_i, MemToReg_i, regDst_i, aluResult_i,
           loadType_i, memData_i, memDataValid_i, flush_i,
    output ready_o, writeRegDst_o, writeRegData_o, RegWrite_o,
           alignErr_o, timeoutErr_o, retired_o
  );
endinterface

// File: rtl/mem_wb_stage_load_align.sv
// load_align: combinational byte/half extraction for loads.
//   data_i       : raw 32-bit word from data memory
//   addr_i       : low two address bits of the load
//   type_i       : load-type code (LW/LH/LHU/LB/LBU, others as LW)
//   result_o     : extracted and sign/zero-extended value
//   misaligned_o : access does not fit its natural alignment
// Little-endian lane selection: byte lane = addr, half lane = addr[1].
module load_align
  import mem_wb_stage_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  type_i,
  output logic [31:0] result_o,
  output logic        misaligned_o
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  assign half_sel = addr_i[1] ? data_i[31:16] : data_i[15:0];

  always_comb begin
    byte_sel = data_i[7:0];
    case (addr_i)
      2'd1:    byte_sel = data_i[15:8];
      2'd2:    byte_sel = data_i[23:16];
      2'd3:    byte_sel = data_i[31:24];
      default: byte_sel = data_i[7:0];
    endcase
  end

  always_comb begin
    result_o     = data_i;
    misaligned_o = DISABLE;
    case (type_i)
      LT_LH: begin
        result_o     = {{16{half_sel[15]}}, half_sel};
        misaligned_o = addr_i[0];
      end
      LT_LHU: begin
        result_o     = {16'h0000, half_sel};
        misaligned_o = addr_i[0];
      end
      LT_LB:  result_o = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU: result_o = {24'h000000, byte_sel};
      default: begin
        result_o     = data_i;
        misaligned_o = (addr_i != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with load alignment.
// Accepts one instruction per cycle from the MEM stage, waits for load data
// when needed, aligns it and drives a registered register-file write port.
// Ports:
//   clk         : clock, rising edge
//   rst         : asynchronous active-low reset
//   bus         : mem_wb_stage_if.slave (handshake, load return, write port,
//                 error pulses, retired counter)
//   dbg_state_o : current FSM state (EMPTY/WAIT_LOAD/COMMIT)
// Parameters:
//   LOAD_TIMEOUT : cycles waited in WAIT_LOAD before giving up
//   RESET_DATA   : reset value of writeRegData_o
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter logic [7:0]  LOAD_TIMEOUT = 8'd255,
  parameter logic [31:0] RESET_DATA   = 32'd0
) (
  input  logic           clk,
  input  logic           rst,
  mem_wb_stage_if.slave  bus,
  output logic [1:0]     dbg_state_o
);

  logic [1:0]  state_q, state_d;
  logic        ready_q, ready_d;
  logic [4:0]  cap_dst_q, cap_dst_d;
  logic        cap_regwrite_q, cap_regwrite_d;
  logic [2:0]  cap_type_q, cap_type_d;
  logic [1:0]  cap_addr_q, cap_addr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  wdst_q, wdst_d;
  logic [31:0] wdata_q, wdata_d;
  logic        regwrite_q, regwrite_d;
  logic        align_err_q, align_err_d;
  logic        timeout_err_q, timeout_err_d;
  logic [31:0] retired_q, retired_d;

  logic        accept;
  logic [7:0]  cnt_inc;
  logic [1:0]  align_addr;
  logic [2:0]  align_type;
  logic [31:0] align_result;
  logic        align_misaligned;

  assign accept  = bus.valid_i & ready_q & ~bus.flush_i;
  assign cnt_inc = cnt_q + 8'd1;

  // One aligner serves both uses: at accept time it checks the incoming
  // address/type for misalignment, in WAIT_LOAD it aligns the returned data
  // with the captured address/type.
  assign align_addr = (state_q == ST_WAIT_LOAD) ? cap_addr_q : bus.aluResult_i[1:0];
  assign align_type = (state_q == ST_WAIT_LOAD) ? cap_type_q : bus.loadType_i;

  load_align u_load_align (
    .data_i       (bus.memData_i),
    .addr_i       (align_addr),
    .type_i       (align_type),
    .result_o     (align_result),
    .misaligned_o (align_misaligned)
  );

  always_comb begin
    state_d        = state_q;
    cap_dst_d      = cap_dst_q;
    cap_regwrite_d = cap_regwrite_q;
    cap_type_d     = cap_type_q;
    cap_addr_d     = cap_addr_q;
    cnt_d          = cnt_q;
    wdst_d         = wdst_q;
    wdata_d        = wdata_q;
    regwrite_d     = DISABLE;
    align_err_d    = DISABLE;
    timeout_err_d  = DISABLE;

    case (state_q)
      ST_WAIT_LOAD: begin
        // Priority: flush, then returned data, then timeout.
        if (bus.flush_i) begin
          state_d = ST_EMPTY;
          cnt_d   = 8'd0;
        end else if (bus.memDataValid_i) begin
          state_d    = ST_COMMIT;
          wdst_d     = cap_dst_q;
          wdata_d    = align_result;
          regwrite_d = cap_regwrite_q & (cap_dst_q != 5'd0);
          cnt_d      = 8'd0;
        end else if (cnt_inc == LOAD_TIMEOUT) begin
          state_d       = ST_EMPTY;
          timeout_err_d = ENABLE;
          cnt_d         = 8'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        // EMPTY and COMMIT behave alike: the commit itself is already on
        // the registered outputs, so this cycle only decides what comes next.
        state_d = ST_EMPTY;
        if (accept) begin
          cap_dst_d      = bus.regDst_i;
          cap_regwrite_d = bus.RegWrite_i;
          cap_type_d     = bus.loadType_i;
          cap_addr_d     = bus.aluResult_i[1:0];
          if (bus.MemToReg_i) begin
            // A misaligned load is rejected up front; no point waiting
            // for data that can never be written.
            if (align_misaligned) begin
              align_err_d = ENABLE;
            end else begin
              state_d = ST_WAIT_LOAD;
              cnt_d   = 8'd0;
            end
          end else begin
            state_d    = ST_COMMIT;
            wdst_d     = bus.regDst_i;
            wdata_d    = bus.aluResult_i;
            regwrite_d = bus.RegWrite_i & (bus.regDst_i != 5'd0);
          end
        end
      end
    endcase

    ready_d   = (state_d != ST_WAIT_LOAD);
    // Counted together with the write so retired_o already includes the
    // write shown on the same cycle.
    retired_d = retired_q + {31'd0, regwrite_d};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_EMPTY;
      ready_q        <= ENABLE;
      cap_dst_q      <= 5'd0;
      cap_regwrite_q <= DISABLE;
      cap_type_q     <= LT_LW;
      cap_addr_q     <= 2'd0;
      cnt_q          <= 8'd0;
      wdst_q         <= 5'd0;
      wdata_q        <= RESET_DATA;
      regwrite_q     <= DISABLE;
      align_err_q    <= DISABLE;
      timeout_err_q  <= DISABLE;
      retired_q      <= ZERO_WORD;
    end else begin
      state_q        <= state_d;
      ready_q        <= ready_d;
      cap_dst_q      <= cap_dst_d;
      cap_regwrite_q <= cap_regwrite_d;
      cap_type_q     <= cap_type_d;
      cap_addr_q     <= cap_addr_d;
      cnt_q          <= cnt_d;
      wdst_q         <= wdst_d;
      wdata_q        <= wdata_d;
      regwrite_q     <= regwrite_d;
      align_err_q    <= align_err_d;
      timeout_err_q  <= timeout_err_d;
      retired_q      <= retired_d;
    end
  end

  assign bus.ready_o        = ready_q;
  assign bus.writeRegDst_o  = wdst_q;
  assign bus.writeRegData_o = wdata_q;
  assign bus.RegWrite_o     = regwrite_q;
  assign bus.alignErr_o     = align_err_q;
  assign bus.timeoutErr_o   = timeout_err_q;
  assign bus.retired_o      = retired_q;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage (LOAD_TIMEOUT=4, RESET_DATA=DEADBEEF).
module tb_mem_wb_stage;

  localparam logic [31:0] RST_DATA = 32'hDEAD_BEEF;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  mem_wb_stage_if bus ();

  mem_wb_stage #(
    .LOAD_TIMEOUT (8'd4),
    .RESET_DATA   (RST_DATA)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_retired;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.valid_i        = 1'b0;
    bus.RegWrite_i     = 1'b0;
    bus.MemToReg_i     = 1'b0;
    bus.regDst_i       = 5'd0;
    bus.aluResult_i    = 32'd0;
    bus.loadType_i     = 3'd0;
    bus.memData_i      = 32'd0;
    bus.memDataValid_i = 1'b0;
    bus.flush_i        = 1'b0;
  endtask

  task automatic drive_alu(input logic [4:0] dst, input logic [31:0] val, input logic rw);
    bus.valid_i     = 1'b1;
    bus.RegWrite_i  = rw;
    bus.MemToReg_i  = 1'b0;
    bus.regDst_i    = dst;
    bus.aluResult_i = val;
  endtask

  task automatic drive_load(input logic [4:0] dst, input logic [31:0] addr, input logic [2:0] ltype);
    bus.valid_i     = 1'b1;
    bus.RegWrite_i  = 1'b1;
    bus.MemToReg_i  = 1'b1;
    bus.regDst_i    = dst;
    bus.aluResult_i = addr;
    bus.loadType_i  = ltype;
  endtask

  // Accept a load, wait 'waits' cycles, return data, then check the commit.
  task automatic load_case(input string tag, input logic [4:0] dst, input logic [31:0] addr,
                           input logic [2:0] ltype, input logic [31:0] data, input int waits,
                           input logic [31:0] exp_data);
    drive_load(dst, addr, ltype);
    step();
    bus.valid_i = 1'b0;
    check({tag, "_ready_wait"}, {31'd0, bus.ready_o}, 32'd0);
    for (int i = 0; i < waits; i++) step();
    bus.memData_i      = data;
    bus.memDataValid_i = 1'b1;
    step();
    bus.memDataValid_i = 1'b0;
    exp_retired = exp_retired + 32'd1;
    check({tag, "_we"},      {31'd0, bus.RegWrite_o}, 32'd1);
    check({tag, "_dst"},     {27'd0, bus.writeRegDst_o}, {27'd0, dst});
    check({tag, "_data"},    bus.writeRegData_o, exp_data);
    check({tag, "_retired"}, bus.retired_o, exp_retired);
  endtask

  initial begin
    drive_idle();
    exp_retired = 32'd0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    check("rst_we",      {31'd0, bus.RegWrite_o}, 32'd0);
    check("rst_dst",     {27'd0, bus.writeRegDst_o}, 32'd0);
    check("rst_data",    bus.writeRegData_o, RST_DATA);
    check("rst_retired", bus.retired_o, 32'd0);
    check("rst_ready",   {31'd0, bus.ready_o}, 32'd1);
    check("rst_state",   {30'd0, dbg_state}, 32'd0);
    rst = 1'b1;

    // ALU op, 1-cycle latency
    drive_alu(5'd5, 32'h1234_5678, 1'b1);
    step();
    bus.valid_i = 1'b0;
    exp_retired = 32'd1;
    check("alu_we",      {31'd0, bus.RegWrite_o}, 32'd1);
    check("alu_dst",     {27'd0, bus.writeRegDst_o}, 32'd5);
    check("alu_data",    bus.writeRegData_o, 32'h1234_5678);
    check("alu_retired", bus.retired_o, 32'd1);
    step();
    check("alu_we_drop", {31'd0, bus.RegWrite_o}, 32'd0);
    check("alu_hold",    bus.writeRegData_o, 32'h1234_5678);
    check("alu_state",   {30'd0, dbg_state}, 32'd0);

    // loads: 3 wait cycles, data arriving on the would-be timeout cycle
    load_case("lb",  5'd7,  32'h0000_1002, 3'b011, 32'h0080_0000, 3, 32'hFFFF_FF80);
    load_case("lbu", 5'd8,  32'h0000_1002, 3'b100, 32'h0080_0000, 3, 32'h0000_0080);
    load_case("lh",  5'd9,  32'h0000_2002, 3'b001, 32'h8001_0000, 0, 32'hFFFF_8001);
    load_case("lhu", 5'd10, 32'h0000_2000, 3'b010, 32'h1234_ABCD, 1, 32'h0000_ABCD);
    load_case("lw",  5'd11, 32'h0000_3000, 3'b000, 32'hCAFE_F00D, 0, 32'hCAFE_F00D);
    load_case("ldef",5'd12, 32'h0000_3004, 3'b111, 32'h0102_0304, 0, 32'h0102_0304);
    load_case("lb3", 5'd13, 32'h0000_3003, 3'b100, 32'hA5B6_C7D8, 0, 32'h0000_00A5);
    step();

    // misaligned LW
    drive_load(5'd14, 32'h0000_4001, 3'b000);
    step();
    bus.valid_i = 1'b0;
    check("lw_mis_err",     {31'd0, bus.alignErr_o}, 32'd1);
    check("lw_mis_we",      {31'd0, bus.RegWrite_o}, 32'd0);
    check("lw_mis_ready",   {31'd0, bus.ready_o}, 32'd1);
    check("lw_mis_retired", bus.retired_o, exp_retired);
    step();
    check("lw_mis_pulse",   {31'd0, bus.alignErr_o}, 32'd0);
    // misaligned LHU
    drive_load(5'd14, 32'h0000_4003, 3'b010);
    step();
    bus.valid_i = 1'b0;
    check("lhu_mis_err",    {31'd0, bus.alignErr_o}, 32'd1);
    step();

    // write to r0 is suppressed
    drive_alu(5'd0, 32'h5555_AAAA, 1'b1);
    step();
    bus.valid_i = 1'b0;
    check("r0_we",      {31'd0, bus.RegWrite_o}, 32'd0);
    check("r0_retired", bus.retired_o, exp_retired);
    // RegWrite_i=0 is suppressed too
    drive_alu(5'd3, 32'h1111_2222, 1'b0);
    step();
    bus.valid_i = 1'b0;
    check("nowr_we", {31'd0, bus.RegWrite_o}, 32'd0);
    step();

    // flush in WAIT_LOAD, then stale data
    drive_load(5'd15, 32'h0000_5000, 3'b000);
    step();
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    check("flush_state", {30'd0, dbg_state}, 32'd0);
    check("flush_ready", {31'd0, bus.ready_o}, 32'd1);
    bus.memData_i      = 32'h7777_7777;
    bus.memDataValid_i = 1'b1;
    step();
    bus.memDataValid_i = 1'b0;
    check("stale_we",      {31'd0, bus.RegWrite_o}, 32'd0);
    check("stale_retired", bus.retired_o, exp_retired);

    // flush and data in the same cycle: flush wins
    drive_load(5'd16, 32'h0000_5000, 3'b000);
    step();
    bus.valid_i        = 1'b0;
    bus.flush_i        = 1'b1;
    bus.memDataValid_i = 1'b1;
    step();
    bus.flush_i        = 1'b0;
    bus.memDataValid_i = 1'b0;
    check("flushdata_we", {31'd0, bus.RegWrite_o}, 32'd0);
    check("flushdata_state", {30'd0, dbg_state}, 32'd0);

    // timeout: pulse 4 cycles after WAIT_LOAD entry
    drive_load(5'd17, 32'h0000_6000, 3'b000);
    step();
    bus.valid_i = 1'b0;
    check("to_ready_wait", {31'd0, bus.ready_o}, 32'd0);
    repeat (3) step();
    check("to_early",      {31'd0, bus.timeoutErr_o}, 32'd0);
    check("to_early_ready",{31'd0, bus.ready_o}, 32'd0);
    step();
    check("to_err",        {31'd0, bus.timeoutErr_o}, 32'd1);
    check("to_ready",      {31'd0, bus.ready_o}, 32'd1);
    check("to_we",         {31'd0, bus.RegWrite_o}, 32'd0);
    step();
    check("to_pulse",      {31'd0, bus.timeoutErr_o}, 32'd0);

    // three back-to-back ALU ops
    for (int i = 0; i < 3; i++) begin
      drive_alu(5'(20 + i), 32'hA000_0000 + 32'(i), 1'b1);
      exp_q.push_back({27'd0, 5'(20 + i)});
      exp_q.push_back(32'hA000_0000 + 32'(i));
      step();
      exp_retired = exp_retired + 32'd1;
      check("b2b_we",      {31'd0, bus.RegWrite_o}, 32'd1);
      check("b2b_dst",     {27'd0, bus.writeRegDst_o}, exp_q.pop_front());
      check("b2b_data",    bus.writeRegData_o, exp_q.pop_front());
      check("b2b_retired", bus.retired_o, exp_retired);
    end
    // flush in COMMIT blocks the same-cycle accept
    drive_alu(5'd25, 32'hBBBB_0000, 1'b1);
    bus.flush_i = 1'b1;
    step();
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    check("cflush_we",    {31'd0, bus.RegWrite_o}, 32'd0);
    check("cflush_hold",  bus.writeRegData_o, 32'hA000_0002);
    check("cflush_state", {30'd0, dbg_state}, 32'd0);

    // reset asserted mid-WAIT_LOAD acts without a clock edge
    drive_load(5'd26, 32'h0000_7000, 3'b000);
    step();
    bus.valid_i = 1'b0;
    check("mid_ready_wait", {31'd0, bus.ready_o}, 32'd0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_state",   {30'd0, dbg_state}, 32'd0);
    check("mid_rst_ready",   {31'd0, bus.ready_o}, 32'd1);
    check("mid_rst_dst",     {27'd0, bus.writeRegDst_o}, 32'd0);
    check("mid_rst_data",    bus.writeRegData_o, RST_DATA);
    check("mid_rst_retired", bus.retired_o, 32'd0);
    check("mid_rst_we",      {31'd0, bus.RegWrite_o}, 32'd0);
    #2 rst = 1'b1;
    // the in-flight load's data returning now is ignored; first accept works
    drive_alu(5'd3, 32'h0BAD_F00D, 1'b1);
    step();
    bus.valid_i = 1'b0;
    check("post_rst_we",      {31'd0, bus.RegWrite_o}, 32'd1);
    check("post_rst_dst",     {27'd0, bus.writeRegDst_o}, 32'd3);
    check("post_rst_data",    bus.writeRegData_o, 32'h0BAD_F00D);
    check("post_rst_retired", bus.retired_o, 32'd1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
